// File: rtl/mux_scan_pkg.sv
// Shared constants, state type and sel stepping for the mux scan controller.
// Define MUX_SCAN_MSB_FIRST_EN to scan bit 7 down to bit 0 instead of 0 up to 7.
package mux_scan_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

`ifdef MUX_SCAN_MSB_FIRST_EN
    localparam logic [SEL_W-1:0] FIRST_SEL = 3'd7;
    localparam logic [SEL_W-1:0] LAST_SEL  = 3'd0;

    function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] s);
        return s - 1'b1;
    endfunction
`else
    localparam logic [SEL_W-1:0] FIRST_SEL = 3'd0;
    localparam logic [SEL_W-1:0] LAST_SEL  = 3'd7;

    function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] s);
        return s + 1'b1;
    endfunction
`endif

endpackage

// File: rtl/mux_scan_ctrl.sv
// Captures a byte and walks an external 8:1 mux select across it, holding each
// select for at least HOLD cycles and advancing only when the consumer is ready.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [DATA_W-1:0] in,
    output logic [SEL_W-1:0]  sel,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              done
);

    localparam int unsigned      CNT_W    = $clog2(HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_in;
    logic [SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic              w_capture;
    logic              w_xfer;
    logic              w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        load_ready   = 1'b0;
        bit_valid    = 1'b0;
        done         = 1'b0;
        w_capture    = 1'b0;
        w_xfer       = 1'b0;
        w_last       = (r_sel == LAST_SEL);
        case (r_state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                bit_valid = 1'b1;
                if ((r_hold_cnt == HOLD_MAX) && bit_ready) begin
                    w_xfer = 1'b1;
                    if (w_last) begin
                        done         = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
        endcase
    end

    // hold_cnt saturates at HOLD-1 so a stalled bit transfers as soon as ready returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in       <= '0;
            r_sel      <= FIRST_SEL;
            r_hold_cnt <= '0;
        end else if (w_capture) begin
            r_in       <= load_data;
            r_sel      <= FIRST_SEL;
            r_hold_cnt <= '0;
        end else if (w_xfer) begin
            r_hold_cnt <= '0;
            if (!w_last) begin
                r_sel <= step_sel(r_sel);
            end
        end else if ((r_state == SCAN) && (r_hold_cnt != HOLD_MAX)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign in  = r_in;
    assign sel = r_sel;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: HOLD=1 and HOLD=3 instances against a
// per-word scan model, directed vector table, corner sequences and random traffic.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif
    localparam logic [2:0] FIRST = MSB ? 3'd7 : 3'd0;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv   [2];
    logic [7:0] ld   [2];
    logic       br   [2];
    logic       lr   [2];
    logic       bv   [2];
    logic       dn   [2];
    logic [7:0] din  [2];
    logic [2:0] dsel [2];

    always #5 clk = ~clk;

    mux_scan_ctrl #(.HOLD(1)) u_h1 (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr[0]),
        .in(din[0]), .sel(dsel[0]), .bit_valid(bv[0]), .bit_ready(br[0]), .done(dn[0])
    );

    mux_scan_ctrl #(.HOLD(3)) u_h3 (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr[1]),
        .in(din[1]), .sel(dsel[1]), .bit_valid(bv[1]), .bit_ready(br[1]), .done(dn[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a word is busy while bits remain; idx = bits already delivered,
    // age = cycles the current bit has been presented so far.
    bit         m_busy [2];
    logic [7:0] m_word [2];
    int         m_idx  [2];
    int         m_age  [2];
    int         hold_of [2] = '{1, 3};

    typedef struct {
        logic       l;
        logic [7:0] d;
        logic       b;
        logic       v;
        int         pos;
        logic       m;
        logic       dn;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] msel(input int j);
        return MSB ? 3'(7 - m_idx[j]) : 3'(m_idx[j]);
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_busy[j] = 1'b0;
            m_word[j] = 8'h00;
            m_idx[j]  = 0;
            m_age[j]  = 0;
        end
    endtask

    task automatic eval();
        #1;
        for (int j = 0; j < 2; j++) begin
            logic [7:0] w;
            logic       ed;
            logic [2:0] es;
            es = msel(j);
            ed = m_busy[j] && (m_age[j] >= hold_of[j] - 1) && br[j] && (m_idx[j] == 7);
            check("ctl", 32'({lr[j], bv[j], dn[j]}), 32'({~m_busy[j], m_busy[j], ed}));
            check("in", 32'(din[j]), 32'(m_word[j]));
            if (m_busy[j]) begin
                w = din[j];
                check("sel", 32'(dsel[j]), 32'(es));
                check("mux", 32'(w[dsel[j]]), 32'(m_word[j][es]));
            end
            if (!m_busy[j]) begin
                if (lv[j]) begin
                    m_busy[j] = 1'b1;
                    m_word[j] = ld[j];
                    m_idx[j]  = 0;
                    m_age[j]  = 0;
                end
            end else if ((m_age[j] >= hold_of[j] - 1) && br[j]) begin
                if (m_idx[j] == 7) begin
                    m_busy[j] = 1'b0;
                end else begin
                    m_idx[j]++;
                    m_age[j] = 0;
                end
            end else begin
                m_age[j]++;
            end
        end
    endtask

    task automatic cyc(input int k, input logic l, input logic [7:0] d, input logic b);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            lv[j] = 1'b0;
            ld[j] = 8'h00;
            br[j] = 1'b0;
        end
        lv[k] = l;
        ld[k] = d;
        br[k] = b;
        eval();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] w;
        int scan_cnt, done_cnt, run, max_run, min_run;
        logic [2:0] prev_sel;

        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 3, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 4, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 5, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 6, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 7, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};

        rst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            lv[j] = 1'b0;
            ld[j] = 8'h00;
            br[j] = 1'b0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int j = 0; j < 2; j++) begin
            check("rst_ctl", 32'({lr[j], bv[j], dn[j]}), 32'(3'b100));
            check("rst_in", 32'(din[j]), 32'h0);
            check("rst_sel", 32'(dsel[j]), 32'(FIRST));
        end
        @(negedge clk);
        rst = 1'b0;

        // A5 scan, HOLD=1, consumer always ready
        for (int i = 0; i < 10; i++) begin
            cyc(0, tbl[i].l, tbl[i].d, tbl[i].b);
            w = din[0];
            check("tv_valid", 32'(bv[0]), 32'(tbl[i].v));
            check("tv_done", 32'(dn[0]), 32'(tbl[i].dn));
            if (tbl[i].v) begin
                check("tv_sel", 32'(dsel[0]), MSB ? 32'(7 - tbl[i].pos) : 32'(tbl[i].pos));
                check("tv_mux", 32'(w[dsel[0]]), 32'(tbl[i].m));
            end
        end

        // Stall five cycles with sel at 4
        cyc(0, 1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 10 && msel(0) != 3'd4; i++) cyc(0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1'b0, 8'h00, 1'b0);
            check("stall_sel", 32'(dsel[0]), 32'd4);
            check("stall_valid", 32'(bv[0]), 32'd1);
            check("stall_done", 32'(dn[0]), 32'd0);
        end
        for (int i = 0; i < 12 && m_busy[0]; i++) cyc(0, 1'b0, 8'h00, 1'b1);

        // Load offered during SCAN is ignored until the following IDLE cycle
        cyc(0, 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 12 && m_busy[0]; i++) begin
            cyc(0, 1'b1, 8'hFF, 1'b1);
            check("ign_in", 32'(din[0]), 32'h3C);
        end
        cyc(0, 1'b1, 8'hFF, 1'b1);
        check("ign_ready", 32'(lr[0]), 32'd1);
        cyc(0, 1'b0, 8'h00, 1'b0);
        check("ign_cap", 32'(din[0]), 32'hFF);
        for (int i = 0; i < 12 && m_busy[0]; i++) cyc(0, 1'b0, 8'h00, 1'b1);

        // HOLD=3: 24 SCAN cycles, every sel held exactly 3 cycles, one done
        cyc(1, 1'b1, 8'hC3, 1'b1);
        scan_cnt = 0; done_cnt = 0; run = 0; max_run = 0; min_run = 99; prev_sel = 3'd0;
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1'b0, 8'h00, 1'b1);
            if (dn[1]) done_cnt++;
            if (bv[1]) begin
                if (scan_cnt > 0 && dsel[1] == prev_sel) begin
                    run++;
                end else begin
                    if (scan_cnt > 0) begin
                        if (run > max_run) max_run = run;
                        if (run < min_run) min_run = run;
                    end
                    run = 1;
                end
                prev_sel = dsel[1];
                scan_cnt++;
            end else if (scan_cnt > 0) begin
                break;
            end
        end
        if (run > max_run) max_run = run;
        if (run < min_run) min_run = run;
        check("h3_scan_cycles", 32'(scan_cnt), 32'd24);
        check("h3_done_pulses", 32'(done_cnt), 32'd1);
        check("h3_max_run", 32'(max_run), 32'd3);
        check("h3_min_run", 32'(min_run), 32'd3);

        // Asynchronous reset in the middle of a word at sel 5
        cyc(0, 1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 10 && msel(0) != 3'd5; i++) cyc(0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            lv[j] = 1'b0;
            br[j] = 1'b0;
        end
        #2;
        check("pre_rst_sel", 32'(dsel[0]), 32'd5);
        rst = 1'b1;
        #1;
        check("arst_in", 32'(din[0]), 32'h0);
        check("arst_sel", 32'(dsel[0]), 32'(FIRST));
        check("arst_ctl", 32'({lr[0], bv[0], dn[0]}), 32'(3'b100));
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic on both instances
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                lv[j] = ($urandom_range(0, 1) == 1);
                ld[j] = 8'($urandom);
                br[j] = ($urandom_range(0, 3) != 0);
            end
            eval();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
